// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON-128 encryption engine.
// Holds the IV, round constant helper, phase enum and the 320-bit state type.
package ascon_pkg;
  localparam int PT_W     = 1448;
  localparam int NBLK     = 22;
  localparam int LAST_W   = 40;
  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 6;

  localparam logic [63:0] IV = 64'h80400C0600000000;

  // Index 0 is x0, so {x4,x3,x2,x1,x0} reads left to right.
  typedef logic [4:0][63:0] state_t;

  typedef enum logic [2:0] {
    IDLE, INIT, AD, ADPAD, PT, FINAL, DONE
  } phase_e;

  function automatic logic [7:0] rc(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction
endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON permutation round.
// Order: constant addition, bitsliced S-box, linear diffusion.
module ascon_round
  import ascon_pkg::*;
(
  input  state_t     s,
  input  logic [3:0] r,
  output state_t     s_nxt
);
  state_t a;
  state_t t;

  always_comb begin
    a = s;
    a[2][7:0] = a[2][7:0] ^ rc(r);
    a[0] = a[0] ^ a[4];
    a[4] = a[4] ^ a[3];
    a[2] = a[2] ^ a[1];
    t[0] = ~a[0] & a[1];
    t[1] = ~a[1] & a[2];
    t[2] = ~a[2] & a[3];
    t[3] = ~a[3] & a[4];
    t[4] = ~a[4] & a[0];
    a[0] = a[0] ^ t[1];
    a[1] = a[1] ^ t[2];
    a[2] = a[2] ^ t[3];
    a[3] = a[3] ^ t[4];
    a[4] = a[4] ^ t[0];
    a[1] = a[1] ^ a[0];
    a[0] = a[0] ^ a[4];
    a[3] = a[3] ^ a[2];
    a[2] = ~a[2];
    s_nxt[0] = a[0] ^ ror64(a[0], 19) ^ ror64(a[0], 28);
    s_nxt[1] = a[1] ^ ror64(a[1], 61) ^ ror64(a[1], 39);
    s_nxt[2] = a[2] ^ ror64(a[2],  1) ^ ror64(a[2],  6);
    s_nxt[3] = a[3] ^ ror64(a[3], 10) ^ ror64(a[3], 17);
    s_nxt[4] = a[4] ^ ror64(a[4],  7) ^ ror64(a[4], 41);
  end
endmodule

// File: rtl/ascon_fsm.sv
// ASCON-128 AEAD encryption, one permutation round per clock.
// Fixed shape: one 64-bit AD block, 22 full message blocks plus a 40-bit tail.
module ascon_fsm
  import ascon_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [PT_W-1:0]   plain_text_i,
  input  logic [127:0]      key_i,
  input  logic [127:0]      nonce_i,
  input  logic [63:0]       da_i,
  output logic [127:0]      tag_o,
  output logic [PT_W-1:0]   cipher_o
);
  phase_e       st_q, st_d;
  logic [3:0]   rnd_q, rnd_d, r_idx;
  logic [4:0]   blk_q, blk_d;
  state_t       x_q, x_d, r_in, r_out;
  logic [127:0] tag_d;
  logic [63:0]  k_hi, k_lo, pt_blk, pl_pad;
  logic         p12, last, ct_clr, ct_blk_we, ct_last_we;

  assign k_hi   = key_i[127:64];
  assign k_lo   = key_i[63:0];
  assign pl_pad = {plain_text_i[LAST_W-1:0], 8'h80, 16'h0};

  always_comb begin
    pt_blk = '0;
    for (int i = 0; i < NBLK; i++)
      if (blk_q == 5'(i)) pt_blk = plain_text_i[PT_W-1-64*i -: 64];
  end

  // p6 phases run the tail of the p12 constant schedule (rounds 6..11).
  assign p12   = (st_q == INIT) || (st_q == FINAL);
  assign r_idx = p12 ? rnd_q : rnd_q + 4'd6;
  assign last  = p12 ? (rnd_q == 4'(ROUNDS_A-1)) : (rnd_q == 4'(ROUNDS_B-1));

  ascon_round u_round (
    .s     (r_in),
    .r     (r_idx),
    .s_nxt (r_out)
  );

  always_comb begin
    st_d       = st_q;
    rnd_d      = rnd_q;
    blk_d      = blk_q;
    x_d        = x_q;
    tag_d      = tag_o;
    r_in       = x_q;
    ct_clr     = 1'b0;
    ct_blk_we  = 1'b0;
    ct_last_we = 1'b0;

    if (rnd_q == 4'd0) begin
      case (st_q)
        AD:    r_in[0] = x_q[0] ^ da_i;
        ADPAD: r_in[0] = x_q[0] ^ 64'h8000000000000000;
        PT:    r_in[0] = x_q[0] ^ pt_blk;
        FINAL: begin
          r_in[0] = x_q[0] ^ pl_pad;
          r_in[1] = x_q[1] ^ k_hi;
          r_in[2] = x_q[2] ^ k_lo;
        end
        default: ;
      endcase
    end

    case (st_q)
      IDLE: if (start_i) begin
        x_d[0] = IV;
        x_d[1] = k_hi;
        x_d[2] = k_lo;
        x_d[3] = nonce_i[127:64];
        x_d[4] = nonce_i[63:0];
        tag_d  = '0;
        ct_clr = 1'b1;
        rnd_d  = '0;
        blk_d  = '0;
        st_d   = INIT;
      end
      DONE: if (!start_i) st_d = IDLE;
      default: begin
        x_d        = r_out;
        rnd_d      = last ? 4'd0 : rnd_q + 4'd1;
        ct_blk_we  = (st_q == PT)    && (rnd_q == 4'd0);
        ct_last_we = (st_q == FINAL) && (rnd_q == 4'd0);
        if (last) begin
          case (st_q)
            INIT: begin
              x_d[3] = r_out[3] ^ k_hi;
              x_d[4] = r_out[4] ^ k_lo;
              st_d   = AD;
            end
            AD:    st_d = ADPAD;
            ADPAD: begin
              x_d[4] = r_out[4] ^ 64'd1;
              blk_d  = '0;
              st_d   = PT;
            end
            PT: begin
              if (blk_q == 5'(NBLK-1)) st_d = FINAL;
              else                     blk_d = blk_q + 5'd1;
            end
            FINAL: begin
              tag_d = {r_out[3] ^ k_hi, r_out[4] ^ k_lo};
              st_d  = DONE;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      st_q     <= IDLE;
      rnd_q    <= '0;
      blk_q    <= '0;
      x_q      <= '0;
      tag_o    <= '0;
      cipher_o <= '0;
    end else begin
      st_q  <= st_d;
      rnd_q <= rnd_d;
      blk_q <= blk_d;
      x_q   <= x_d;
      tag_o <= tag_d;
      if (ct_clr) cipher_o <= '0;
      for (int i = 0; i < NBLK; i++)
        if (ct_blk_we && blk_q == 5'(i)) cipher_o[PT_W-1-64*i -: 64] <= r_in[0];
      // Only the top 40 bits of the padded tail block are real ciphertext.
      if (ct_last_we) cipher_o[LAST_W-1:0] <= r_in[0][63:24];
    end
  end
endmodule

// File: tb/tb_ascon_fsm.sv
// Directed bench for ascon_fsm against an S-box-table ASCON-128 model.
// Covers reset, two full vectors, DONE hold, restart and mid-run reset.
module tb_ascon_fsm;
  import ascon_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1447:0] pt;
  logic [127:0]  key, nonce;
  logic [63:0]   ad;
  logic [127:0]  tag;
  logic [1447:0] ct;

  state_t        rs, rs_o;
  logic [3:0]    rr;

  int checks = 0;
  int errors = 0;

  logic [127:0]  exp_tag, tag_z;
  logic [1447:0] exp_ct, ct_z;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  always #5 clk = ~clk;

  ascon_fsm dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .start_i      (start),
    .plain_text_i (pt),
    .key_i        (key),
    .nonce_i      (nonce),
    .da_i         (ad),
    .tag_o        (tag),
    .cipher_o     (ct)
  );

  ascon_round u_rnd (
    .s     (rs),
    .r     (rr),
    .s_nxt (rs_o)
  );

  task automatic chk(input string name, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic chk_ct(input string name, input logic [1447:0] exp);
    for (int i = 0; i < 22; i++)
      chk($sformatf("%s_b%0d", name, i), 320'(ct[1447-64*i -: 64]), 320'(exp[1447-64*i -: 64]));
    chk($sformatf("%s_tail", name), 320'(ct[39:0]), 320'(exp[39:0]));
  endtask

  function automatic logic [63:0] rot(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  function automatic state_t m_round(input state_t s, input int r);
    state_t o, q;
    logic [4:0] v, w;
    s[2] = s[2] ^ 64'(((15 - r) << 4) | r);
    for (int b = 0; b < 64; b++) begin
      v = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
      w = SBOX[v];
      for (int j = 0; j < 5; j++) o[j][b] = w[4-j];
    end
    for (int j = 0; j < 5; j++) q[j] = o[j] ^ rot(o[j], ROT_A[j]) ^ rot(o[j], ROT_B[j]);
    return q;
  endfunction

  function automatic state_t m_perm(input state_t s, input int first);
    for (int r = first; r < 12; r++) s = m_round(s, r);
    return s;
  endfunction

  task automatic model(input logic [127:0] k, input logic [127:0] n, input logic [63:0] a,
                       input logic [1447:0] p, output logic [127:0] tg, output logic [1447:0] c);
    state_t s;
    c = '0;
    s[0] = 64'h80400C0600000000;
    s[1] = k[127:64]; s[2] = k[63:0]; s[3] = n[127:64]; s[4] = n[63:0];
    s = m_perm(s, 0);
    s[3] ^= k[127:64]; s[4] ^= k[63:0];
    s[0] ^= a;
    s = m_perm(s, 6);
    s[0] ^= 64'h8000000000000000;
    s = m_perm(s, 6);
    s[4] ^= 64'd1;
    for (int i = 0; i < 22; i++) begin
      s[0] ^= p[1447-64*i -: 64];
      c[1447-64*i -: 64] = s[0];
      s = m_perm(s, 6);
    end
    s[0] ^= {p[39:0], 8'h80, 16'h0000};
    c[39:0] = s[0][63:24];
    s[1] ^= k[127:64]; s[2] ^= k[63:0];
    s = m_perm(s, 0);
    tg = {s[3] ^ k[127:64], s[4] ^ k[63:0]};
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pt = '0; key = '0; nonce = '0; ad = '0;
    rs = '0; rr = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_tag", 320'(tag), 320'(0));
    chk("rst_ct", 320'(ct[1447:1384]), 320'(0));
    chk("rst_st", 320'(dut.st_q), 320'(IDLE));

    // Isolated round: arbitrary state, first and last constant.
    rs = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'hDEADBEEFCAFEF00D,
          64'h5A5AA5A5C3C33C3C, 64'h0F1E2D3C4B5A6978};
    rr = 4'd0; #1;
    chk("round_r0", rs_o, m_round(rs, 0));
    rr = 4'd11; #1;
    chk("round_r11", rs_o, m_round(rs, 11));

    // All-zero vector, start held high throughout.
    model(key, nonce, ad, pt, tag_z, ct_z);
    start = 1'b1;
    repeat (168) @(posedge clk);
    #1 chk("z_tag_e168", 320'(tag), 320'(0));
    @(posedge clk);
    #1 chk("z_tag_e169", 320'(tag), 320'(tag_z));
    chk_ct("z_ct", ct_z);
    repeat (25) @(posedge clk);
    #1 chk("z_tag_hold", 320'(tag), 320'(tag_z));
    chk("z_ct_hold", 320'(ct[1447:1384]), 320'(ct_z[1447:1384]));
    chk("z_st_done", 320'(dut.st_q), 320'(DONE));

    // One-cycle start drop then restart: outputs clear, same result.
    start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 chk("re_tag_clr", 320'(tag), 320'(0));
    chk("re_ct_clr", 320'(ct[1447:1384]), 320'(0));
    repeat (167) @(posedge clk);
    #1 chk("re_tag_e168", 320'(tag), 320'(0));
    @(posedge clk);
    #1 chk("re_tag", 320'(tag), 320'(tag_z));
    chk_ct("re_ct", ct_z);

    // Counting-byte vector.
    start = 1'b0;
    @(posedge clk);
    #1;
    key   = 128'h000102030405060708090A0B0C0D0E0F;
    nonce = 128'h000102030405060708090A0B0C0D0E0F;
    ad    = 64'h0001020304050607;
    for (int i = 0; i < 181; i++) pt[1447-8*i -: 8] = 8'(i);
    model(key, nonce, ad, pt, exp_tag, exp_ct);
    start = 1'b1;
    repeat (169) @(posedge clk);
    #1 chk("v_tag", 320'(tag), 320'(exp_tag));
    chk_ct("v_ct", exp_ct);

    // Reset 50 edges into a run, then restart straight out of reset.
    start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    repeat (50) @(posedge clk);
    #1 chk("mid_ct_b0", 320'(ct[1447:1384]), 320'(exp_ct[1447:1384]));
    chk("mid_tag", 320'(tag), 320'(0));
    #1 rst = 1'b1;
    #1 chk("mid_rst_tag", 320'(tag), 320'(0));
    chk("mid_rst_ct", 320'(ct[1447:1384]), 320'(0));
    chk("mid_rst_ct_b1", 320'(ct[1383:1320]), 320'(0));
    chk("mid_rst_st", 320'(dut.st_q), 320'(IDLE));
    #1 rst = 1'b0;
    repeat (168) @(posedge clk);
    #1 chk("rr_tag_e168", 320'(tag), 320'(0));
    @(posedge clk);
    #1 chk("rr_tag", 320'(tag), 320'(exp_tag));
    chk_ct("rr_ct", exp_ct);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
